// File: rtl/rockband_pkg.sv
// Shared types and geometry helpers for the rhythm-game VGA colour path.
package rockband_pkg;

  // Sprite mode per lane; the numeric value doubles as the sprite slot index in the ROM.
  typedef enum logic [1:0] {
    PAD_IDLE    = 2'd0,
    PAD_PRESSED = 2'd1,
    PAD_FLASH   = 2'd2
  } pad_mode_t;

  // Left x of lane i (counted from the left); lanes at or beyond split get the extra gap.
  function automatic logic [10:0] lane_x(input int unsigned i,
                                         input int unsigned x0,
                                         input int unsigned pitch,
                                         input int unsigned split,
                                         input int unsigned gap);
    int unsigned x;
    x = x0 + i * pitch + ((i >= split) ? gap : 0);
    return x[10:0];
  endfunction

  // First ROM row of the sprite for a given mode.
  function automatic int unsigned sprite_base(input pad_mode_t mode, input int unsigned pad_h);
    return int'(mode) * pad_h;
  endfunction

endpackage

// File: rtl/target_pads_if.sv
// Sprite ROM bus: registered row address out, row data back one cycle later.
interface target_pads_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned PAD_W  = 32
);
  logic [ADDR_W-1:0] rom_addr;
  logic [PAD_W-1:0]  rom_data;

  modport master (output rom_addr, input rom_data);
  modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/pad_lane_ctrl.sv
// Per-lane frame-latched sprite mode: key level, pending hit and hit-flash countdown.
module pad_lane_ctrl
  import rockband_pkg::*;
#(
  parameter int unsigned FLASH_FRAMES = 8
) (
  input  logic      Clk,
  input  logic      Reset,
  input  logic      frame_start,
  input  logic      key,
  input  logic      hit,
  output pad_mode_t mode
);

  localparam int unsigned CNT_W = $clog2(FLASH_FRAMES + 1);

  logic             key_q;
  logic             pend_q;
  logic [CNT_W-1:0] flash_cnt_q;

  // State only moves on frame_start so the pad never changes look mid-frame; hits are
  // remembered in pend_q until then, and a hit coinciding with frame_start counts at once.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      key_q       <= 1'b0;
      pend_q      <= 1'b0;
      flash_cnt_q <= '0;
    end else if (frame_start) begin
      key_q  <= key;
      pend_q <= 1'b0;
      if (pend_q || hit) begin
        flash_cnt_q <= CNT_W'(FLASH_FRAMES);
      end else if (flash_cnt_q != '0) begin
        flash_cnt_q <= flash_cnt_q - 1'b1;
      end
    end else if (hit) begin
      pend_q <= 1'b1;
    end
  end

  // Flash overrides pressed, pressed overrides idle.
  always_comb begin
    mode = PAD_IDLE;
    if (flash_cnt_q != '0) begin
      mode = PAD_FLASH;
    end else if (key_q) begin
      mode = PAD_PRESSED;
    end
  end

endmodule

// File: rtl/target_pads.sv
// Lane target pads: hit test, sprite ROM addressing and 3-cycle coverage pipeline.
module target_pads
  import rockband_pkg::*;
#(
  parameter int unsigned NUM_LANES    = 8,
  parameter int unsigned PAD_W        = 32,
  parameter int unsigned PAD_H        = 18,
  parameter int unsigned PAD_Y        = 360,
  parameter int unsigned LANE_X0      = 64,
  parameter int unsigned LANE_PITCH   = 54,
  parameter int unsigned SPLIT        = 4,
  parameter int unsigned SPLIT_GAP    = 102,
  parameter int unsigned FLASH_FRAMES = 8,
  // Three sprites of PAD_H rows must fit in the ROM address space.
  parameter int unsigned ADDR_W       = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 frame_start,
  input  logic [9:0]           DrawX,
  input  logic [9:0]           DrawY,
  input  logic [NUM_LANES-1:0] keyTrack,
  input  logic [NUM_LANES-1:0] hit,
  target_pads_if.master        rom,
  output logic [NUM_LANES-1:0] is_sr
);

  localparam int unsigned COL_W = (PAD_W > 1) ? $clog2(PAD_W) : 1;

  logic [10:0]       x_in;
  logic [10:0]       y_in;
  logic              y_in_pad;
  logic [ADDR_W-1:0] row;

  assign x_in     = {1'b0, DrawX};
  assign y_in     = {1'b0, DrawY};
  assign y_in_pad = (y_in >= 11'(PAD_Y)) && (y_in < 11'(PAD_Y + PAD_H));
  assign row      = ADDR_W'(y_in - 11'(PAD_Y));

  // Arrays below are indexed by lane from the left; lane i maps to mask bit NUM_LANES-1-i.
  pad_mode_t            lane_mode [NUM_LANES];
  logic [NUM_LANES-1:0] lane_in;
  logic [COL_W-1:0]     lane_col  [NUM_LANES];

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam logic [10:0] LX = lane_x(i, LANE_X0, LANE_PITCH, SPLIT, SPLIT_GAP);

    assign lane_in[i]  = y_in_pad && (x_in >= LX) && (x_in < LX + 11'(PAD_W));
    assign lane_col[i] = COL_W'(x_in - LX);

    pad_lane_ctrl #(
      .FLASH_FRAMES(FLASH_FRAMES)
    ) u_ctrl (
      .Clk        (Clk),
      .Reset      (Reset),
      .frame_start(frame_start),
      .key        (keyTrack[NUM_LANES-1-i]),
      .hit        (hit[NUM_LANES-1-i]),
      .mode       (lane_mode[i])
    );
  end

  logic                 sel_found;
  logic [NUM_LANES-1:0] sel_oh;
  logic [COL_W-1:0]     sel_col;
  logic [ADDR_W-1:0]    sel_addr;

  // Pick the first (leftmost) covering lane; no lane leaves address, mask and column at 0.
  always_comb begin
    sel_found = 1'b0;
    sel_oh    = '0;
    sel_col   = '0;
    sel_addr  = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (!sel_found && lane_in[i]) begin
        sel_found               = 1'b1;
        sel_oh[NUM_LANES-1-i]   = 1'b1;
        sel_col                 = lane_col[i];
        sel_addr                = ADDR_W'(sprite_base(lane_mode[i], PAD_H)) + row;
      end
    end
  end

  logic [ADDR_W-1:0]    rom_addr_q;
  logic [NUM_LANES-1:0] oh_s1_q;
  logic [COL_W-1:0]     col_s1_q;
  logic [NUM_LANES-1:0] oh_s2_q;
  logic [COL_W-1:0]     col_s2_q;
  logic [NUM_LANES-1:0] is_sr_q;
  logic                 pix;

  assign rom.rom_addr = rom_addr_q;
  assign is_sr        = is_sr_q;

  // Stage 1: register ROM address plus the lane one-hot and column that go with it.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rom_addr_q <= '0;
      oh_s1_q    <= '0;
      col_s1_q   <= '0;
    end else begin
      rom_addr_q <= sel_addr;
      oh_s1_q    <= sel_oh;
      col_s1_q   <= sel_col;
    end
  end

  // Stage 2: hold lane/column while the ROM produces the row.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      oh_s2_q  <= '0;
      col_s2_q <= '0;
    end else begin
      oh_s2_q  <= oh_s1_q;
      col_s2_q <= col_s1_q;
    end
  end

  // Column 0 is the leftmost pixel, stored in the ROM word MSB.
  always_comb begin
    pix = 1'b0;
    for (int b = 0; b < PAD_W; b++) begin
      if (col_s2_q == COL_W'(PAD_W - 1 - b)) begin
        pix = rom.rom_data[b];
      end
    end
  end

  // Stage 3: coverage mask is the lane one-hot gated by the sprite pixel.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      is_sr_q <= '0;
    end else begin
      is_sr_q <= pix ? oh_s2_q : '0;
    end
  end

endmodule

// File: tb/tb_target_pads.sv
// Directed bench for target_pads: geometry, modes, flash timing and async reset.
module tb_target_pads;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_start = 1'b0;
  logic [9:0] DrawX = '0;
  logic [9:0] DrawY = '0;
  logic [7:0] keyTrack = '0;
  logic [7:0] hit = '0;
  logic [7:0] is_sr;
  logic [31:0] rom_word = 32'h8000_0000;

  int total = 0;
  int bad = 0;

  target_pads_if #(.ADDR_W(8), .PAD_W(32)) rom_bus ();

  target_pads dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_start(frame_start),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .keyTrack   (keyTrack),
    .hit        (hit),
    .rom        (rom_bus.master),
    .is_sr      (is_sr)
  );

  always #5 Clk = ~Clk;

  // Synchronous ROM model: every row returns rom_word, one cycle after the address.
  always @(posedge Clk) rom_bus.rom_data <= rom_word;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hold a pixel for three cycles: address checked after one edge, mask after three.
  task automatic probe(input string tag, input logic [9:0] x, input logic [9:0] y,
                       input logic [7:0] exp_addr, input logic [7:0] exp_sr);
    DrawX = x;
    DrawY = y;
    step();
    check({tag, "_addr"}, 32'(rom_bus.rom_addr), 32'(exp_addr));
    step();
    step();
    check({tag, "_sr"}, 32'(is_sr), 32'(exp_sr));
  endtask

  task automatic frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  initial begin
    // Reset state
    step();
    check("rst_addr", 32'(rom_bus.rom_addr), 32'h0);
    check("rst_sr", 32'(is_sr), 32'h0);
    Reset = 1'b0;
    step();

    // Idle pad, leftmost lane
    rom_word = 32'h8000_0000;
    probe("idle_c0", 10'd64, 10'd360, 8'd0, 8'h80);
    probe("idle_c1", 10'd65, 10'd360, 8'd0, 8'h00);
    rom_word = 32'h0000_0001;
    probe("idle_c31", 10'd95, 10'd377, 8'd17, 8'h80);

    // Edges and gaps with a fully set sprite row
    rom_word = 32'hFFFF_FFFF;
    probe("x_past", 10'd96, 10'd360, 8'd0, 8'h00);
    probe("y_below", 10'd64, 10'd378, 8'd0, 8'h00);
    probe("y_above", 10'd64, 10'd359, 8'd0, 8'h00);
    probe("gap_split", 10'd300, 10'd360, 8'd0, 8'h00);
    probe("gap_lane", 10'd100, 10'd360, 8'd0, 8'h00);
    probe("lane4", 10'd382, 10'd360, 8'd0, 8'h08);
    probe("lane7_end", 10'd575, 10'd365, 8'd5, 8'h01);

    // Pressed mode is frame-latched
    keyTrack = 8'h80;
    probe("press_mid", 10'd64, 10'd360, 8'd0, 8'h80);
    frame();
    probe("press_on", 10'd64, 10'd365, 8'd23, 8'h80);
    keyTrack = 8'h00;
    probe("press_hold", 10'd64, 10'd365, 8'd23, 8'h80);
    frame();
    probe("press_off", 10'd64, 10'd365, 8'd5, 8'h80);

    // Flash lasts exactly FLASH_FRAMES frames
    hit = 8'h08;
    step();
    hit = 8'h00;
    probe("flash_pend", 10'd382, 10'd360, 8'd0, 8'h08);
    for (int f = 0; f < 8; f++) begin
      frame();
      probe($sformatf("flash_f%0d", f + 1), 10'd382, 10'd360, 8'd36, 8'h08);
    end
    probe("flash_other", 10'd64, 10'd360, 8'd0, 8'h80);
    keyTrack = 8'h08;
    frame();
    probe("flash_end_key", 10'd382, 10'd360, 8'd18, 8'h08);
    keyTrack = 8'h00;
    frame();
    probe("flash_end_idle", 10'd382, 10'd360, 8'd0, 8'h08);

    // Hit together with frame_start, then a re-hit in flash frame 5
    frame_start = 1'b1;
    hit = 8'h01;
    step();
    frame_start = 1'b0;
    hit = 8'h00;
    probe("sim_f1", 10'd544, 10'd360, 8'd36, 8'h01);
    for (int f = 2; f <= 5; f++) begin
      frame();
      probe($sformatf("sim_f%0d", f), 10'd544, 10'd360, 8'd36, 8'h01);
    end
    hit = 8'h01;
    step();
    hit = 8'h00;
    for (int f = 0; f < 8; f++) begin
      frame();
      probe($sformatf("rehit_f%0d", f + 1), 10'd544, 10'd360, 8'd36, 8'h01);
    end
    frame();
    probe("rehit_end", 10'd544, 10'd360, 8'd0, 8'h01);

    // Async reset in flash frame 3
    hit = 8'h80;
    step();
    hit = 8'h00;
    frame();
    frame();
    frame();
    probe("rstf_pre", 10'd64, 10'd360, 8'd36, 8'h80);
    #2;
    Reset = 1'b1;
    #1;
    check("rstf_addr", 32'(rom_bus.rom_addr), 32'h0);
    check("rstf_sr", 32'(is_sr), 32'h0);
    step();
    Reset = 1'b0;
    probe("rstf_post", 10'd64, 10'd360, 8'd0, 8'h80);
    frame();
    probe("rstf_next", 10'd64, 10'd360, 8'd0, 8'h80);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/target_pads.md
# target_pads

Parametrised, pipelined successor to the static lane target rectangles. For each of `NUM_LANES` lanes it decides per pixel whether the lane's target pad sprite covers (DrawX, DrawY), fetches the sprite row from an external synchronous sprite ROM, and emits a one-hot per-lane coverage mask. Each lane has three sprite modes: idle, pressed and hit-flash. The mode is frame-latched so a pad never changes appearance mid-frame. The block sits in the VGA colour path between the key/scoring logic and the colour mapper.

## Interface
- `NUM_LANES`, 8, lane count. MSB is the leftmost lane.
- `PAD_W`, 32, sprite width in pixels. Also the `rom_data` width.
- `PAD_H`, 18, sprite height in rows.
- `PAD_Y`, 360, top row of all pads.
- `LANE_X0`, 64, left x of the leftmost lane.
- `LANE_PITCH`, 54, x distance between adjacent lanes.
- `SPLIT`, 4, lane index (from the left) at which `SPLIT_GAP` starts to apply.
- `SPLIT_GAP`, 102, extra x offset for lanes at index ≥ `SPLIT`.
- `FLASH_FRAMES`, 8, number of frames a hit flash lasts.
- `ADDR_W`, 8, ROM address width. Must satisfy 3·`PAD_H` ≤ 2^`ADDR_W`.
- `Clk` in 1: the only clock.
- `Reset` in 1: asynchronous, active-high.
- `frame_start` in 1: one-cycle pulse at the start of vertical blank.
- `DrawX`, `DrawY` in 10 each: current pixel.
- `keyTrack` in `NUM_LANES`: level, key held per lane.
- `hit` in `NUM_LANES`: one-cycle pulse per lane from scoring.
- `rom_addr` out `ADDR_W`: registered sprite ROM row address.
- `rom_data` in `PAD_W`: ROM row, valid the cycle after `rom_addr`. Bit `PAD_W-1` is the leftmost pixel.
- `is_sr` out `NUM_LANES`: registered one-hot coverage mask.

## Operation
- **Lane geometry.** Lane i counts from the left; i=0 drives bit `NUM_LANES-1`. x_i = `LANE_X0` + i·`LANE_PITCH` + (i≥`SPLIT` ? `SPLIT_GAP` : 0). Defaults give 64, 118, 172, 226, 382, 436, 490, 544.
- **Hit test.** A lane is hit when x_i ≤ DrawX < x_i+`PAD_W` and `PAD_Y` ≤ DrawY < `PAD_Y`+`PAD_H`.
  - Lanes never overlap. Lower i takes priority if parameters make them overlap.
  - All comparisons are 11-bit unsigned.
- **Per-lane frame state**, updated only on `frame_start`:
  - `key_q` ← `keyTrack` bit.
  - `pend` is set by a `hit` pulse in any cycle. It is cleared on `frame_start`.
  - On `frame_start`: if `pend` or `hit` is asserted that cycle, `flash_cnt` ← `FLASH_FRAMES`. Otherwise, if `flash_cnt` ≠ 0, it decrements by 1.
  - A re-hit during a flash reloads the counter.
  - `flash_cnt` width is $clog2(`FLASH_FRAMES`+1).
- **Mode and ROM address.** Mode is FLASH if `flash_cnt` ≠ 0, else PRESSED if `key_q`, else IDLE.
  - Sprite base = mode·`PAD_H` (0, 18, 36).
  - `rom_addr` = base + (DrawY − `PAD_Y`).
- **No lane hit.** `rom_addr` = 0, the pipeline lane-valid bit is 0, and `is_sr` = 0 regardless of `rom_data`.
- **Coverage.** `is_sr` = lane one-hot if `rom_data`[`PAD_W`−1−col] = 1, where col = DrawX − x_lane (5-bit for the default).

## Timing
- **Pipeline.**
  - Cycle t: DrawX/DrawY sampled.
  - t+1: `rom_addr`, the lane one-hot and col are registered.
  - t+2: `rom_data` valid.
  - t+3: `is_sr` registered.
  - Total latency is 3 cycles. The parent delays other colour layers to match.
- **Mode changes.** A mode change becomes visible on the first pixel sampled after the `frame_start` edge.
- **Reset values.** `rom_addr`=0, `is_sr`=0, all pipeline registers 0, `key_q`=0, `pend`=0, `flash_cnt`=0.
- **Reset mid-frame or mid-flash.** Takes effect immediately and asynchronously. The next frame starts in IDLE.
- **Simultaneous `hit` and `frame_start`.** The hit is counted in that update; it is not deferred to the next frame.

## Structure
- Package `rockband_pkg`:
  - `pad_mode_t` enum {PAD_IDLE=0, PAD_PRESSED=1, PAD_FLASH=2}.
  - Function `lane_x(i)` implementing the geometry formula.
  - Sprite base constant = mode·`PAD_H`.
- Sub-module `pad_lane_ctrl`, instantiated `NUM_LANES` times by generate. It holds `key_q`, `pend` and `flash_cnt`, and outputs `pad_mode_t`.
- Top level: hit test, address mux and the three-stage pipeline.

## Test plan
- **Idle pad.** After reset, drive DrawX=64, DrawY=360; the ROM model returns 32'h8000_0000 → `rom_addr`=0 at t+1, `is_sr`=8'b1000_0000 at t+3. Repeat with DrawX=65 → `is_sr`=0.
- **Pressed mode.** Set `keyTrack`=8'h80 mid-frame → `rom_addr` stays 0 until `frame_start`. On the next frame, DrawY=365 gives `rom_addr`=23.
- **Flash duration.** Pulse `hit`[3], then run frames. Lane at x=382, DrawY=360 → `rom_addr`=36 for exactly 8 frames, then 0 (or 18 if `keyTrack`[3] is held).
- **Gaps.** DrawX=300 (split gap) and DrawX=100 (inter-lane gap), with `rom_data`=32'hFFFF_FFFF → `is_sr`=0, `rom_addr`=0.
- **Simultaneous events.** `hit`[0] asserted in the same cycle as `frame_start` → flash active the next frame. A re-hit at flash frame 5 → flash lasts 8 more frames.
- **Async reset mid-flash.** Assert `Reset` at flash frame 3 → `is_sr` and `rom_addr` go to 0 immediately; after release, the lane is IDLE (`rom_addr`=0 on a hit).
